// File: rtl/alu_rr_arbiter_pkg.sv
// Shared ALU types for the arbitrated ALU slice: operation encoding, flag
// bundle and arbiter control state, imported by every file of the block.
package alu_rr_arbiter_pkg;

   localparam int BIT_COUNT = 32;
   localparam int SH_W      = $clog2(BIT_COUNT);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } aluOperation;

   // Shared with the branch logic, so field order is fixed as {Z, V, N, C}.
   typedef struct packed {
      logic Zero;
      logic oVerflow;
      logic Negative;
      logic Carry;
   } aluFlags;

   typedef enum logic {
      ARB_HOLD = 1'b0,
      ARB_RUN  = 1'b1
   } arb_state_e;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between the ALU requesters and the shared ALU arbiter.
// master = requesters plus response consumer, slave = the arbiter.
interface alu_rr_arbiter_if
   import alu_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = id_width(NUM_REQ)
);

   logic        [NUM_REQ-1:0]                ReqValid;
   logic        [NUM_REQ-1:0]                ReqReady;
   aluOperation [NUM_REQ-1:0]                ReqOp;
   logic        [NUM_REQ-1:0][BIT_COUNT-1:0] ReqOperandA;
   logic        [NUM_REQ-1:0][BIT_COUNT-1:0] ReqOperandB;

   logic                 RespValid;
   logic                 RespReady;
   logic [ID_W-1:0]      RespId;
   logic [BIT_COUNT-1:0] RespResult;
   aluFlags              RespFlags;

   modport master (
      output ReqValid, ReqOp, ReqOperandA, ReqOperandB, RespReady,
      input  ReqReady, RespValid, RespId, RespResult, RespFlags
   );

   modport slave (
      input  ReqValid, ReqOp, ReqOperandA, ReqOperandB, RespReady,
      output ReqReady, RespValid, RespId, RespResult, RespFlags
   );

endinterface

// File: rtl/alu_rr_arbiter_rr_grant_ptr.sv
// Round-robin grant: searches the request vector from the pointer with wrap,
// returns a one-hot grant, its encoded index and the pointer for the next cycle.
module rr_grant_ptr
   import alu_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    winner,
   output logic               found,
   output logic [ID_W-1:0]    ptr_next
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop so no latch is inferred.
      idx    = 0;
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            winner     = ID_W'(idx);
         end
      end
   end

   // The pointer moves to the slot after the winner, and only on a real grant.
   always_comb begin
      ptr_next = ptr;
      if (advance && found)
         ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// One behavioural ALU shared by NUM_REQ requesters via round-robin arbitration,
// with a one-entry registered response slot. Optional counters: ALU_ARB_PERF_EN.
module alu_rr_arbiter
   import alu_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   alu_rr_arbiter_if.slave          bus
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [NUM_REQ-1:0][31:0] GrantCount,
   output logic [NUM_REQ-1:0][31:0] StallCount
`endif
);

   arb_state_e           state;
   logic [ID_W-1:0]      ptr;
   logic [ID_W-1:0]      ptr_next;
   logic [ID_W-1:0]      winner;
   logic [NUM_REQ-1:0]   grant;
   logic                 found;
   logic                 slot_free;
   logic                 handshake;

   aluOperation          alu_op;
   logic [BIT_COUNT-1:0] alu_a;
   logic [BIT_COUNT-1:0] alu_b;
   logic [BIT_COUNT:0]   alu_wide;
   logic [BIT_COUNT-1:0] alu_result;
   aluFlags              alu_flags;

   // The slot can be drained and refilled on the same edge.
   assign slot_free = ~bus.RespValid | bus.RespReady;
   assign handshake = (state == ARB_RUN) & slot_free & found;
   assign bus.ReqReady = handshake ? grant : '0;

   rr_grant_ptr #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_grant (
      .req      (bus.ReqValid),
      .ptr      (ptr),
      .advance  (handshake),
      .grant    (grant),
      .winner   (winner),
      .found    (found),
      .ptr_next (ptr_next)
   );

   // winner is 0 when nobody requests, so the idle mux selects requester 0.
   assign alu_op = bus.ReqOp[winner];
   assign alu_a  = bus.ReqOperandA[winner];
   assign alu_b  = bus.ReqOperandB[winner];

   always_comb begin
      alu_wide           = '0;
      alu_result         = '0;
      alu_flags.Carry    = 1'b0;
      alu_flags.oVerflow = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            alu_wide           = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result         = alu_wide[BIT_COUNT-1:0];
            alu_flags.Carry    = alu_wide[BIT_COUNT];
            alu_flags.oVerflow = (alu_a[BIT_COUNT-1] == alu_b[BIT_COUNT-1]) &&
                                 (alu_result[BIT_COUNT-1] != alu_a[BIT_COUNT-1]);
         end
         ALU_SUB: begin
            // Carry reports a borrow on subtraction (set when A < B unsigned).
            alu_wide           = {1'b0, alu_a} - {1'b0, alu_b};
            alu_result         = alu_wide[BIT_COUNT-1:0];
            alu_flags.Carry    = alu_wide[BIT_COUNT];
            alu_flags.oVerflow = (alu_a[BIT_COUNT-1] != alu_b[BIT_COUNT-1]) &&
                                 (alu_result[BIT_COUNT-1] != alu_a[BIT_COUNT-1]);
         end
         ALU_AND:  alu_result = alu_a & alu_b;
         ALU_OR:   alu_result = alu_a | alu_b;
         ALU_XOR:  alu_result = alu_a ^ alu_b;
         ALU_SLT:  alu_result = BIT_COUNT'($signed(alu_a) < $signed(alu_b));
         ALU_SLTU: alu_result = BIT_COUNT'(alu_a < alu_b);
         ALU_SLL:  alu_result = alu_a << alu_b[SH_W-1:0];
         ALU_SRL:  alu_result = alu_a >> alu_b[SH_W-1:0];
         ALU_SRA:  alu_result = $signed(alu_a) >>> alu_b[SH_W-1:0];
         default: begin
            alu_result         = 'x;
            alu_flags.Carry    = 1'bx;
            alu_flags.oVerflow = 1'bx;
         end
      endcase
      alu_flags.Zero     = (alu_result == '0);
      alu_flags.Negative = alu_result[BIT_COUNT-1];
   end

   // ARB_HOLD keeps ReqReady low until the first edge after reset is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ARB_HOLD;
         ptr            <= '0;
         bus.RespValid  <= 1'b0;
         bus.RespId     <= '0;
         bus.RespResult <= '0;
         bus.RespFlags  <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
         state <= ARB_RUN;
         ptr   <= ptr_next;
         if (handshake) begin
            bus.RespValid  <= 1'b1;
            bus.RespId     <= winner;
            bus.RespResult <= alu_result;
            bus.RespFlags  <= alu_flags;
         end else if (bus.RespValid && bus.RespReady) begin
            bus.RespValid <= 1'b0;
         end
      end
   end

`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         GrantCount <= '0;
         StallCount <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.ReqValid[i] && bus.ReqReady[i])
               GrantCount[i] <= GrantCount[i] + 32'd1;
            if (bus.ReqValid[i] && !bus.ReqReady[i])
               StallCount[i] <= StallCount[i] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomised and directed bench for alu_rr_arbiter: a driver keeps an arithmetic
// reference of arbitration and the ALU, a separate monitor scores responses.
module tb_alu_rr_arbiter;
   import alu_rr_arbiter_pkg::*;

   localparam int N  = 2;
   localparam int IW = id_width(N);
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 64'sd1;

   typedef enum int {P_IDLE, P_ALT, P_SLT, P_OVF, P_RAND} phase_e;

   typedef struct {
      logic [IW-1:0] id;
      logic [31:0]   result;
      logic [3:0]    flags;
   } resp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   alu_rr_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

`ifdef ALU_ARB_PERF_EN
   logic [N-1:0][31:0] grant_count;
   logic [N-1:0][31:0] stall_count;
`endif

   alu_rr_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef ALU_ARB_PERF_EN
      ,
      .GrantCount (grant_count),
      .StallCount (stall_count)
`endif
   );

   int     errors = 0;
   int     checks = 0;
   resp_t  sb[$];
   bit     mon_en = 1'b0;
   phase_e phase  = P_IDLE;
   bit     slt_toggle = 1'b0;
   bit     m_valid, m_run;
   int     m_ptr;
   int     m_grant[N];
   int     m_stall[N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic resp_t model_alu(input int id, input aluOperation op,
                                       input logic [31:0] a, input logic [31:0] b);
      resp_t  r;
      longint ua, ub, sa, sbv, s;
      bit     c, v;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sbv = longint'($signed(b));
      c = 1'b0;
      v = 1'b0;
      s = 0;
      case (op)
         ALU_ADD: begin
            s = ua + ub;
            r.result = s[31:0];
            c = (s > 64'sd4294967295);
            v = (sa + sbv > SMAX) || (sa + sbv < SMIN);
         end
         ALU_SUB: begin
            s = ua - ub;
            r.result = s[31:0];
            c = (ua < ub);
            v = (sa - sbv > SMAX) || (sa - sbv < SMIN);
         end
         ALU_AND:  r.result = a & b;
         ALU_OR:   r.result = a | b;
         ALU_XOR:  r.result = a ^ b;
         ALU_SLT:  r.result = (sa < sbv) ? 32'd1 : 32'd0;
         ALU_SLTU: r.result = (ua < ub) ? 32'd1 : 32'd0;
         ALU_SLL:  r.result = a << b[4:0];
         ALU_SRL:  r.result = a >> b[4:0];
         ALU_SRA: begin
            s = sa >>> b[4:0];
            r.result = s[31:0];
         end
         default:  r.result = 32'd0;
      endcase
      r.id    = IW'(id);
      r.flags = {r.result == 32'd0, v, r.result[31], c};
      return r;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic set_req(input int i, input logic v, input aluOperation op,
                          input logic [31:0] a, input logic [31:0] b);
      bus.ReqValid[i]    = v;
      bus.ReqOp[i]       = op;
      bus.ReqOperandA[i] = a;
      bus.ReqOperandB[i] = b;
   endtask

   // Requester i presents its next operation according to the current phase.
   task automatic next_req(input int i);
      case (phase)
         P_ALT:
            if (i == 0) set_req(i, 1'b1, ALU_ADD, 32'd5, 32'd7);
            else        set_req(i, 1'b1, ALU_SUB, 32'd3, 32'd5);
         P_SLT:
            if (i == 1) begin
               set_req(i, 1'b1, slt_toggle ? ALU_SLTU : ALU_SLT, 32'hFFFF_FFFF, 32'd1);
               slt_toggle = ~slt_toggle;
            end else begin
               set_req(i, 1'b0, ALU_ADD, 32'd0, 32'd0);
            end
         P_OVF:
            if (i == 0) set_req(i, 1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
            else        set_req(i, 1'b0, ALU_ADD, 32'd0, 32'd0);
         P_RAND:
            set_req(i, $urandom_range(0, 3) != 0, aluOperation'(4'($urandom_range(0, 9))),
                    rand_operand(), rand_operand());
         default:
            set_req(i, 1'b0, ALU_ADD, 32'd0, 32'd0);
      endcase
   endtask

   task automatic set_phase(input phase_e p);
      phase = p;
      slt_toggle = 1'b0;
      for (int i = 0; i < N; i++) next_req(i);
   endtask

   // Called at posedge+1; asserts reset mid-cycle and checks outputs clear at once.
   task automatic do_reset();
      #1;
      reset  = 1'b1;
      mon_en = 1'b0;
      #1;
      check("rst_resp_valid",  bus.RespValid,  1'b0);
      check("rst_resp_id",     bus.RespId,     '0);
      check("rst_resp_result", bus.RespResult, 32'd0);
      check("rst_resp_flags",  bus.RespFlags,  4'd0);
      check("rst_req_ready",   bus.ReqReady,   '0);
      sb.delete();
      m_valid = 1'b0;
      m_run   = 1'b0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) begin
         m_grant[i] = 0;
         m_stall[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_ready", bus.ReqReady, '0);
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   // One cycle: predict ReqReady from the current inputs, then apply the edge.
   task automatic step();
      int            w;
      bit            hs;
      resp_t         item;
      logic [N-1:0]  exp_ready;
      @(negedge clk);
      w = -1;
      hs = 1'b0;
      exp_ready = '0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (w < 0 && bus.ReqValid[idx]) w = idx;
      end
      if (m_run && (!m_valid || bus.RespReady) && w >= 0) begin
         hs = 1'b1;
         exp_ready[w] = 1'b1;
      end
      check("req_ready",  bus.ReqReady,  exp_ready);
      check("resp_valid", bus.RespValid, m_valid);
      for (int i = 0; i < N; i++) begin
         if (bus.ReqValid[i]) begin
            if (exp_ready[i]) m_grant[i]++;
            else              m_stall[i]++;
         end
      end
      if (hs) item = model_alu(w, bus.ReqOp[w], bus.ReqOperandA[w], bus.ReqOperandB[w]);
      @(posedge clk);
      #1;
      m_run = 1'b1;
      if (hs) begin
         sb.push_back(item);
         m_valid = 1'b1;
         m_ptr   = (w + 1) % N;
      end else if (m_valid && bus.RespReady) begin
         m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++)
         if ((hs && i == w) || (phase == P_RAND && !bus.ReqValid[i])) next_req(i);
   endtask

   always @(negedge clk) begin
      if (mon_en && bus.RespValid === 1'b1) begin
         if (sb.size() == 0) begin
            check("resp_unexpected", bus.RespValid, 1'b0);
         end else begin
            check("resp_id",     bus.RespId,     sb[0].id);
            check("resp_result", bus.RespResult, sb[0].result);
            check("resp_flags",  bus.RespFlags,  sb[0].flags);
            if (bus.RespReady) void'(sb.pop_front());
         end
      end
   end

   initial begin
      bus.RespReady = 1'b1;
      set_phase(P_ALT);
      @(posedge clk);
      do_reset();

      // Both requesters always valid: strict alternation, one result per cycle.
      repeat (8) step();

      // Reset while a response is in flight, then resume.
      do_reset();
      repeat (3) step();

      // Backpressure with a response waiting, then drain and refill together.
      bus.RespReady = 1'b0;
      repeat (3) step();
      bus.RespReady = 1'b1;
      repeat (4) step();

      set_phase(P_SLT);
      repeat (8) step();

      set_phase(P_OVF);
      repeat (3) step();

      set_phase(P_RAND);
      for (int c = 0; c < 400; c++) begin
         step();
         bus.RespReady = ($urandom_range(0, 3) != 0);
         if (c == 200) do_reset();
      end

      set_phase(P_IDLE);
      bus.RespReady = 1'b1;
      repeat (4) step();
      check("sb_empty", sb.size(), 0);
`ifdef ALU_ARB_PERF_EN
      for (int i = 0; i < N; i++) begin
         check("grant_count", grant_count[i], m_grant[i]);
         check("stall_count", stall_count[i], m_stall[i]);
      end
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
